// File: rtl/red_pitaya_pll_lock_seq.sv
// MMCM lock monitor and ADC/DAC reset sequencer, clocked by the free-running reference clock.
// Optional statistics counters are built only when PLL_LOCK_STATS_EN is defined.
module red_pitaya_pll_lock_seq #(
  parameter int LOCK_CYC    = 1024,
  parameter int STAGE_CYC   = 16,
  parameter int TIMEOUT_CYC = 65536,
  parameter int PLLRST_CYC  = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked_i,
  input  logic             stats_clr_i,
  output logic             pll_rst_o,
  output logic             rst_adc_o,
  output logic             rst_dac_o,
  output logic             ready_o,
  output logic [CNT_W-1:0] loss_cnt_o,
  output logic [CNT_W-1:0] retry_cnt_o
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(LOCK_CYC, STAGE_CYC), max2(TIMEOUT_CYC, PLLRST_CYC));
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] LOCK_LD    = TW'(LOCK_CYC - 1);
  localparam logic [TW-1:0] STAGE_LD   = TW'(STAGE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] PLLRST_LD  = TW'(PLLRST_CYC - 1);

  typedef enum logic [2:0] {
    ST_PLLRST,
    ST_WAIT,
    ST_STABLE,
    ST_REL_ADC,
    ST_RUN
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          sync1_q, lock_s_q;
  logic          pll_rst_q, pll_rst_d;
  logic          rst_adc_q, rst_adc_d;
  logic          rst_dac_q, rst_dac_d;
  logic          ready_q, ready_d;
  logic          inc_loss, inc_retry;

  // NOTE: sequential state is written with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let sync1_q fall straight through to lock_s_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked_i;
      lock_s_q <= sync1_q;
    end
  end

  // NOTE: every always_comb output gets a default before the case, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    inc_loss  = 1'b0;
    inc_retry = 1'b0;
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == '0) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A lock arriving on the timeout cycle takes priority over the retry.
        if (lock_s_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == '0) begin
          state_d   = ST_PLLRST;
          inc_retry = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lock_s_q)          state_d = ST_WAIT;
        else if (cnt_q == '0)   state_d = ST_REL_ADC;
      end
      ST_REL_ADC: begin
        if (!lock_s_q)          state_d = ST_WAIT;
        else if (cnt_q == '0)   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d  = ST_WAIT;
          inc_loss = 1'b1;
        end
      end
      default: state_d = ST_PLLRST;
    endcase
  end

  // The single down-counter reloads whenever a new state is entered.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_PLLRST:  cnt_d = PLLRST_LD;
        ST_WAIT:    cnt_d = TIMEOUT_LD;
        ST_STABLE:  cnt_d = LOCK_LD;
        ST_REL_ADC: cnt_d = STAGE_LD;
        default:    cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Outputs are decoded from the current state and registered, so they trail the state by one edge.
  always_comb begin
    pll_rst_d = (state_q == ST_PLLRST);
    rst_adc_d = !((state_q == ST_REL_ADC) || (state_q == ST_RUN));
    rst_dac_d = (state_q != ST_RUN);
    ready_d   = (state_q == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PLLRST;
      cnt_q     <= PLLRST_LD;
      pll_rst_q <= 1'b1;
      rst_adc_q <= 1'b1;
      rst_dac_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= pll_rst_d;
      rst_adc_q <= rst_adc_d;
      rst_dac_q <= rst_dac_d;
      ready_q   <= ready_d;
    end
  end

  assign pll_rst_o = pll_rst_q;
  assign rst_adc_o = rst_adc_q;
  assign rst_dac_o = rst_dac_q;
  assign ready_o   = ready_q;

`ifdef PLL_LOCK_STATS_EN
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;

  // Clear beats a coincident increment; both counters stick at all-ones.
  always_comb begin
    loss_cnt_d  = loss_cnt_q;
    retry_cnt_d = retry_cnt_q;
    if (stats_clr_i) begin
      loss_cnt_d  = '0;
      retry_cnt_d = '0;
    end else begin
      if (inc_loss && (loss_cnt_q != '1))   loss_cnt_d  = loss_cnt_q + CNT_W'(1);
      if (inc_retry && (retry_cnt_q != '1)) retry_cnt_d = retry_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_q  <= '0;
      retry_cnt_q <= '0;
    end else begin
      loss_cnt_q  <= loss_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign loss_cnt_o  = loss_cnt_q;
  assign retry_cnt_o = retry_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{stats_clr_i, inc_loss, inc_retry};
  assign loss_cnt_o   = '0;
  assign retry_cnt_o  = '0;
`endif

endmodule
